// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if
// Groups the flag-write, instruction-issue and execute-result signals of
// cond_flag_unit.
//   master : the upstream/downstream side (drives flag writes, issue, exec_ready)
//   slave  : cond_flag_unit itself
// Parameter CNT_W sets the width of skip_cnt and must match the unit's CNT_W.
interface cond_flag_unit_if #(
    parameter int CNT_W = 16
);
    logic             flag_wr_valid;
    logic             flag_wr_s;
    logic [3:0]       new_flag;
    logic             flag_busy;
    logic             instr_valid;
    logic [3:0]       instr_cond;
    logic             instr_ready;
    logic             exec_valid;
    logic             exec_pass;
    logic [3:0]       exec_cond;
    logic             exec_ready;
    logic [3:0]       flags;
    logic [CNT_W-1:0] skip_cnt;

    modport master (
        output flag_wr_valid, flag_wr_s, new_flag, flag_busy,
        output instr_valid, instr_cond, exec_ready,
        input  instr_ready, exec_valid, exec_pass, exec_cond, flags, skip_cnt
    );

    modport slave (
        input  flag_wr_valid, flag_wr_s, new_flag, flag_busy,
        input  instr_valid, instr_cond, exec_ready,
        output instr_ready, exec_valid, exec_pass, exec_cond, flags, skip_cnt
    );
endinterface

// File: rtl/cond_flag_unit.sv
// cond_flag_unit
// Holds the NZCV register, evaluates each issuing instruction's condition
// field against it, and presents a one-deep registered pass/fail result to
// execute. Stalls issue while a flag write is in flight and counts
// condition-failed instructions (saturating).
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cond_flag_unit_if.slave (flag write, issue, exec result, flags, skip_cnt)
// Build option: define COND_FLAG_FWD_EN to forward a same-cycle flag write
// into condition evaluation instead of stalling on it.
//
// state | meaning
// IDLE  | result slot empty, exec_valid=0
// HOLD  | result slot full, exec_valid=1, waiting for exec_ready
module cond_flag_unit #(
    parameter int         CNT_W     = 16,
    parameter logic [3:0] RST_FLAGS = 4'b0000
) (
    input logic            clk,
    input logic            rst_n,
    cond_flag_unit_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    state_t           state_q, state_d;
    logic [3:0]       flags_q;
    logic             pass_q, pass_d;
    logic [3:0]       cond_q, cond_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             flag_we;
    logic [3:0]       eval_flags;
    logic             hazard;
    logic             stall;
    logic             slot_free;
    logic             ready;
    logic             accept;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        case (c)
            4'd0:    cond_pass = z;
            4'd1:    cond_pass = !z;
            4'd2:    cond_pass = cy;
            4'd3:    cond_pass = !cy;
            4'd4:    cond_pass = n;
            4'd5:    cond_pass = !n;
            4'd6:    cond_pass = v;
            4'd7:    cond_pass = !v;
            4'd8:    cond_pass = cy && !z;
            4'd9:    cond_pass = !cy || z;
            4'd10:   cond_pass = (n == v);
            4'd11:   cond_pass = (n != v);
            4'd12:   cond_pass = !z && (n == v);
            4'd13:   cond_pass = z || (n != v);
            4'd14:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign flag_we = bus.flag_wr_valid && bus.flag_wr_s;

`ifdef COND_FLAG_FWD_EN
    assign eval_flags = flag_we ? bus.new_flag : flags_q;
    assign hazard     = bus.flag_busy;
`else
    assign eval_flags = flags_q;
    assign hazard     = bus.flag_busy || flag_we;
`endif

    // AL and NV do not depend on the flags, so they never wait on a write.
    assign stall = hazard && (bus.instr_cond != COND_AL) && (bus.instr_cond != COND_NV);

    always_comb begin
        state_d   = state_q;
        pass_d    = pass_q;
        cond_d    = cond_q;
        cnt_d     = cnt_q;
        slot_free = 1'b0;
        case (state_q)
            IDLE:    slot_free = 1'b1;
            HOLD:    slot_free = bus.exec_ready;
            default: slot_free = 1'b0;
        endcase
        ready  = slot_free && !stall;
        accept = bus.instr_valid && ready;
        if (accept) begin
            state_d = HOLD;
            cond_d  = bus.instr_cond;
            pass_d  = cond_pass(bus.instr_cond, eval_flags);
            if (!pass_d && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if ((state_q == HOLD) && bus.exec_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pass_q  <= 1'b0;
            cond_q  <= 4'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            cond_q  <= cond_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            flags_q <= RST_FLAGS;
        else if (flag_we)
            flags_q <= bus.new_flag;
    end

    assign bus.instr_ready = ready;
    assign bus.exec_valid  = (state_q == HOLD);
    assign bus.exec_pass   = pass_q;
    assign bus.exec_cond   = cond_q;
    assign bus.flags       = flags_q;
    assign bus.skip_cnt    = cnt_q;
endmodule

// File: tb/tb_cond_flag_unit.sv
module tb_cond_flag_unit;
    logic clk;
    logic rst_n;

    cond_flag_unit_if #(.CNT_W(16)) ifm ();
    cond_flag_unit_if #(.CNT_W(2))  ifs ();

    cond_flag_unit #(.CNT_W(16), .RST_FLAGS(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .bus(ifm)
    );
    cond_flag_unit #(.CNT_W(2), .RST_FLAGS(4'b0000)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        logic [3:0] cond;
        bit         pass;
    } exp_t;
    exp_t exp_q[$];

    // Reference condition table straight from the mnemonic definitions.
    function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            0:  return z;
            1:  return !z;
            2:  return cy;
            3:  return !cy;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return cy && !z;
            9:  return !cy || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1;
            default: return 0;
        endcase
    endfunction

    // Drive one cycle of inputs at the falling edge into both instances.
    task automatic cyc(input bit rst, input bit wv, input bit ws, input logic [3:0] nf,
                       input bit busy, input bit iv, input logic [3:0] cond, input bit er);
        @(negedge clk);
        rst_n = rst;
        ifm.flag_wr_valid = wv; ifs.flag_wr_valid = wv;
        ifm.flag_wr_s     = ws; ifs.flag_wr_s     = ws;
        ifm.new_flag      = nf; ifs.new_flag      = nf;
        ifm.flag_busy     = busy; ifs.flag_busy   = busy;
        ifm.instr_valid   = iv; ifs.instr_valid   = iv;
        ifm.instr_cond    = cond; ifs.instr_cond  = cond;
        ifm.exec_ready    = er; ifs.exec_ready    = er;
    endtask

    // Reference model + per-cycle checks, evaluated mid low-phase.
    bit         m_held;
    logic [3:0] m_flags;
    int         m_skip;

    initial begin
        m_held = 0; m_flags = 4'b0000; m_skip = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                m_held = 0; m_flags = 4'b0000; m_skip = 0;
                exp_q.delete();
                check("rst_flags", ifm.flags, 4'b0000);
                check("rst_exec_valid", ifm.exec_valid, 0);
                check("rst_skip", ifm.skip_cnt, 0);
                check("rst_skip_s", ifs.skip_cnt, 0);
            end else begin
                bit we, stall, rdy, acc, p;
                logic [3:0] eff;
                check("flags", ifm.flags, m_flags);
                check("exec_valid", ifm.exec_valid, m_held);
                check("skip_cnt", ifm.skip_cnt, (m_skip > 65535) ? 65535 : m_skip);
                check("skip_cnt_sat", ifs.skip_cnt, (m_skip > 3) ? 3 : m_skip);
                we = ifm.flag_wr_valid && ifm.flag_wr_s;
`ifdef COND_FLAG_FWD_EN
                eff   = we ? ifm.new_flag : m_flags;
                stall = ifm.flag_busy && !(ifm.instr_cond inside {4'd14, 4'd15});
`else
                eff   = m_flags;
                stall = (ifm.flag_busy || we) && !(ifm.instr_cond inside {4'd14, 4'd15});
`endif
                rdy = (!m_held || ifm.exec_ready) && !stall;
                check("instr_ready", ifm.instr_ready, rdy);
                check("instr_ready_s", ifs.instr_ready, rdy);
                acc = ifm.instr_valid && rdy;
                if (acc) begin
                    exp_t e;
                    p = ref_cond(ifm.instr_cond, eff);
                    e.cond = ifm.instr_cond;
                    e.pass = p;
                    exp_q.push_back(e);
                    if (!p) m_skip++;
                end
                m_held = acc || (m_held && !ifm.exec_ready);
                if (we) m_flags = ifm.new_flag;
            end
        end
    end

    // Monitor: compares the presented result against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ifm.exec_valid) begin
                if (exp_q.size() == 0) begin
                    check("exec_unexpected", ifm.exec_valid, 0);
                end else begin
                    check("exec_cond", ifm.exec_cond, exp_q[0].cond);
                    check("exec_pass", ifm.exec_pass, exp_q[0].pass);
                    if (ifm.exec_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ifm.flag_wr_valid = 0; ifs.flag_wr_valid = 0;
        ifm.flag_wr_s = 0;     ifs.flag_wr_s = 0;
        ifm.new_flag = 0;      ifs.new_flag = 0;
        ifm.flag_busy = 0;     ifs.flag_busy = 0;
        ifm.instr_valid = 0;   ifs.instr_valid = 0;
        ifm.instr_cond = 0;    ifs.instr_cond = 0;
        ifm.exec_ready = 1;    ifs.exec_ready = 1;

        // Reset with flag writes active
        repeat (3) cyc(0, 1, 1, 4'hF, 0, 1, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 0, 4'd0, 1);
        // Flag write then EQ / NE, ignored S=0 write
        cyc(1, 1, 1, 4'b0100, 0, 0, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd1, 1);
        cyc(1, 1, 0, 4'hB, 0, 0, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd0, 1);
        // Signed conditions
        cyc(1, 1, 1, 4'b1001, 0, 0, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd10, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd11, 1);
        cyc(1, 1, 1, 4'b1000, 0, 0, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd12, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd13, 1);
        // Hazard: busy stalls EQ, AL passes under busy
        repeat (3) cyc(1, 0, 0, 4'h0, 1, 1, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 1, 1, 4'd14, 1);
        cyc(1, 0, 0, 4'h0, 0, 0, 4'd0, 1);
        // Same-cycle write with EQ, then retry
        cyc(1, 1, 1, 4'b0100, 0, 1, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd0, 1);
        // Same-cycle write with AL
        cyc(1, 1, 1, 4'b0000, 0, 1, 4'd14, 1);
        // Backpressure then back-to-back drain
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd1, 0);
        repeat (4) cyc(1, 0, 0, 4'h0, 0, 1, 4'd5, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 4'h0, 0, 1, 4'(i), 1);
        // Saturation from a clean counter: 5 NV back-to-back
        cyc(0, 0, 0, 4'h0, 0, 0, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 0, 4'd0, 1);
        repeat (5) cyc(1, 0, 0, 4'h0, 0, 1, 4'd15, 1);
        // Reset in HOLD drops the result immediately
        cyc(1, 0, 0, 4'h0, 0, 1, 4'd14, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_hold_valid", ifm.exec_valid, 0);
        cyc(0, 0, 0, 4'h0, 0, 0, 4'd0, 1);
        cyc(1, 0, 0, 4'h0, 0, 0, 4'd0, 1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            cyc((i % 700) != 699,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1,
                4'($urandom),
                $urandom_range(0, 4) == 0,
                $urandom_range(0, 3) != 0,
                4'($urandom),
                $urandom_range(0, 3) != 0);
        end
        repeat (4) cyc(1, 0, 0, 4'h0, 0, 0, 4'd0, 1);
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
